// File: rtl/uart_rx_ctrl_if.sv
// Receive-side byte handshake between uart_rx_ctrl (master) and its consumer.
interface uart_rx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 valid_out;
    logic                 ready_in;

    modport master (output data_out, valid_out, input  ready_in);
    modport slave  (input  data_out, valid_out, output ready_in);
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver: mid-bit sampling FSM with a one-deep valid/ready output holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             sig_in,
    uart_rx_ctrl_if.master   bus,
    output logic             busy_out,
    output logic             frame_err_out,
    output logic             overrun_out
);
    localparam logic [13:0] HALF = 14'(CLKS_PER_BIT / 2 - 1);
    localparam logic [13:0] FULL = 14'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state;
    logic [13:0]          timer;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 stop_ok;

`ifdef UART_RX_PARITY_EN
    logic par_err;
    assign stop_ok = sig_in && !par_err;
`else
    assign stop_ok = sig_in;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            timer         <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            busy_out      <= 1'b0;
            frame_err_out <= 1'b0;
            overrun_out   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err       <= 1'b0;
`endif
        end else begin
            frame_err_out <= 1'b0;
            overrun_out   <= 1'b0;
            // A consumed byte drops valid unless a new byte loads below in the same cycle.
            if (bus.valid_out && bus.ready_in)
                bus.valid_out <= 1'b0;

            case (state)
                IDLE: begin
                    timer   <= '0;
                    bit_idx <= '0;
                    if (!sig_in) begin
                        state    <= START;
                        busy_out <= 1'b1;
                    end
                end
                START: begin
                    if (timer == HALF) begin
                        timer    <= '0;
                        state    <= sig_in ? IDLE : DATA;
                        busy_out <= !sig_in;
                    end else begin
                        timer <= timer + 14'd1;
                    end
                end
                DATA: begin
                    if (timer == FULL) begin
                        timer   <= '0;
                        shift   <= {sig_in, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST) begin
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end
                    end else begin
                        timer <= timer + 14'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (timer == FULL) begin
                        timer   <= '0;
                        par_err <= sig_in != (^shift);
                        state   <= STOP;
                    end else begin
                        timer <= timer + 14'd1;
                    end
                end
`endif
                STOP: begin
                    if (timer == FULL) begin
                        timer <= '0;
                        if (stop_ok) begin
                            state    <= IDLE;
                            busy_out <= 1'b0;
                            // Holding register still full and not being drained: drop the new byte.
                            if (bus.valid_out && !bus.ready_in) begin
                                overrun_out <= 1'b1;
                            end else begin
                                bus.data_out  <= shift;
                                bus.valid_out <= 1'b1;
                            end
                        end else begin
                            frame_err_out <= 1'b1;
                            state         <= sig_in ? IDLE : WAIT_HIGH;
                            busy_out      <= !sig_in;
                        end
                    end else begin
                        timer <= timer + 14'd1;
                    end
                end
                WAIT_HIGH: begin
                    timer <= '0;
                    if (sig_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10417: clock cycles per bit (100 MHz, 9600 baud); legal range 4..16383.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-003 The block SHALL have port clk_in, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_in, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sig_in, input, 1 bit: serial line, already synchronized and sampled upstream; idle level is 1.
REQ-006 The block SHALL have port data_out, output, DATA_BITS bits: received byte, LSB first on the line.
REQ-007 The block SHALL have port valid_out, output, 1 bit: data_out holds an unconsumed byte.
REQ-008 The block SHALL have port ready_in, input, 1 bit: consumer accepts data_out this cycle.
REQ-009 The block SHALL have port busy_out, output, 1 bit: a frame is in progress (state is not IDLE).
REQ-010 The block SHALL have port frame_err_out, output, 1 bit: one-cycle pulse when the stop bit samples 0.
REQ-011 The block SHALL have port overrun_out, output, 1 bit: one-cycle pulse when a completed byte is dropped.

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY (only when PARITY_EN is defined), STOP and WAIT_HIGH.
REQ-013 In IDLE, when sig_in==0, the FSM SHALL go to START and clear the 14-bit bit-timer.
REQ-014 In START, at timer==CLKS_PER_BIT/2-1 (integer division), the FSM SHALL go to DATA if sig_in==0 and clear the timer; if sig_in==1 it SHALL treat the event as a glitch and return to IDLE with no output.
REQ-015 In DATA, at timer==CLKS_PER_BIT-1, the FSM SHALL shift sig_in into the MSB of the shift register (shift right), clear the timer and increment the 3-bit bit index; after bit DATA_BITS-1 it SHALL go to PARITY or STOP.
REQ-016 In STOP, at timer==CLKS_PER_BIT-1, if sig_in==1 the byte SHALL complete and the FSM SHALL go to IDLE; if sig_in==0 frame_err_out SHALL pulse, the byte SHALL be discarded and the FSM SHALL go to WAIT_HIGH.
REQ-017 WAIT_HIGH SHALL go to IDLE on the first cycle in which sig_in==1.
REQ-018 On completion, data_out SHALL load and valid_out SHALL rise on the clock edge after the stop-bit sample cycle (latency 1 cycle).
REQ-019 valid_out and data_out SHALL hold until a cycle with valid_out && ready_in; valid_out SHALL then drop on the next edge unless a new byte completes in the same cycle.
REQ-020 If a byte completes while valid_out==1 and ready_in==0, overrun_out SHALL pulse, the new byte SHALL be dropped and the old data_out SHALL be kept.
REQ-021 If a byte completes in the same cycle as valid_out && ready_in, the new byte SHALL load, valid_out SHALL stay 1 and overrun_out SHALL stay 0.
REQ-022 The timer SHALL never wrap; it SHALL be cleared at every sample point and in IDLE.
REQ-023 busy_out SHALL be 1 in START, DATA, PARITY, STOP and WAIT_HIGH, and 0 in IDLE.

Reset
REQ-024 When rst_in==0, the block SHALL immediately force state=IDLE, timer=0, bit index=0, shift register=0, data_out=0, valid_out=0, busy_out=0, frame_err_out=0 and overrun_out=0.
REQ-025 An assertion of rst_in mid-frame SHALL abandon the frame with no error pulse; after deassertion, a line held low SHALL start a new START detect.

Configuration
REQ-026 With UART_RX_PARITY_EN defined, the block SHALL add a PARITY state after DATA, sample one even-parity bit at timer==CLKS_PER_BIT-1, and, on a parity mismatch, pulse frame_err_out on the stop-bit sample cycle and discard the byte even if the stop bit is 1.
REQ-027 Without UART_RX_PARITY_EN, the block SHALL have no PARITY state; DATA SHALL go directly to STOP, and the frame SHALL be start + DATA_BITS + stop.

Verification (CLKS_PER_BIT=16, DATA_BITS=8; a bit is 16 cycles)
REQ-028 Frame 0x35 (line 0,1,0,1,0,1,1,0,0,1) with ready_in=1 -> data_out=0x35 and valid_out high for exactly 1 cycle, 1 cycle after the stop sample.
REQ-029 A 4-cycle low glitch on an idle line -> FSM returns to IDLE; no valid_out, frame_err_out or overrun_out.
REQ-030 Frame 0xA5 with stop bit 0, then line high -> one frame_err_out pulse, valid_out stays 0, busy_out falls 1 cycle after the line returns to 1.
REQ-031 Frames 0x11 then 0x22 with ready_in=0 -> data_out=0x11, one overrun_out pulse; raising ready_in for 1 cycle clears valid_out.
REQ-032 rst_in low for 2 cycles during data bit 3 of frame 0x5A -> all outputs 0 immediately; the next clean frame 0x5A is received correctly.
REQ-033 With UART_RX_PARITY_EN defined: 0x07 with parity 1 -> accepted; 0x07 with parity 0 -> frame_err_out pulses and no valid_out.
